// File: rtl/tri_tile_raster.sv
// Triangle scan-conversion front end: bbox/tile clip, LANES-wide incremental edge walk, valid/ready beats.
// Optional macro TRI_RASTER_BACKFACE_CULL_EN drops negative-area triangles instead of flipping them.
module tri_tile_raster #(
  parameter int COORD_W = 16,
  parameter int LANES   = 4,
  parameter int EW      = 2*COORD_W+2
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_draw,
  input  logic signed [COORD_W-1:0] i_v1_x,
  input  logic signed [COORD_W-1:0] i_v1_y,
  input  logic signed [COORD_W-1:0] i_v2_x,
  input  logic signed [COORD_W-1:0] i_v2_y,
  input  logic signed [COORD_W-1:0] i_v3_x,
  input  logic signed [COORD_W-1:0] i_v3_y,
  input  logic signed [COORD_W-1:0] i_tile_x0,
  input  logic signed [COORD_W-1:0] i_tile_y0,
  input  logic signed [COORD_W-1:0] i_tile_x1,
  input  logic signed [COORD_W-1:0] i_tile_y1,
  output logic                      o_busy,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [COORD_W-1:0] o_x,
  output logic signed [COORD_W-1:0] o_y,
  output logic [LANES-1:0]          o_mask,
  output logic signed [EW-1:0]      o_e1,
  output logic signed [EW-1:0]      o_e2,
  output logic signed [EW-1:0]      o_e3,
  output logic signed [EW-1:0]      o_area,
  output logic                      o_done
);

  localparam int XW = COORD_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CLIP  = 3'd2,
    S_INIT  = 3'd3,
    S_SCAN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic signed [COORD_W-1:0] smin(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [COORD_W-1:0] smax(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // (px-xa)*sx + (py-ya)*sy, with sx = yb-ya and sy = xa-xb
  function automatic logic signed [EW-1:0] edge_eval(input logic signed [COORD_W-1:0] px,
                                                     input logic signed [COORD_W-1:0] py,
                                                     input logic signed [COORD_W-1:0] xa,
                                                     input logic signed [COORD_W-1:0] ya,
                                                     input logic signed [EW-1:0]      sx,
                                                     input logic signed [EW-1:0]      sy);
    logic signed [EW-1:0] ddx;
    logic signed [EW-1:0] ddy;
    ddx = EW'(px) - EW'(xa);
    ddy = EW'(py) - EW'(ya);
    return ddx * sx + ddy * sy;
  endfunction

  state_t                     state_q, state_d;
  logic signed [COORD_W-1:0]  vx_q [3];
  logic signed [COORD_W-1:0]  vx_d [3];
  logic signed [COORD_W-1:0]  vy_q [3];
  logic signed [COORD_W-1:0]  vy_d [3];
  logic signed [COORD_W-1:0]  tx0_q, tx0_d, ty0_q, ty0_d, tx1_q, tx1_d, ty1_q, ty1_d;
  logic signed [COORD_W-1:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic signed [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic signed [EW-1:0]       dx_q [3];
  logic signed [EW-1:0]       dx_d [3];
  logic signed [EW-1:0]       dy_q [3];
  logic signed [EW-1:0]       dy_d [3];
  logic signed [EW-1:0]       e_q [3];
  logic signed [EW-1:0]       e_d [3];
  logic signed [EW-1:0]       r_q [3];
  logic signed [EW-1:0]       r_d [3];
  logic signed [EW-1:0]       area_q, area_d;
  logic                       last_q, last_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [COORD_W-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;
  logic [LANES-1:0]           out_mask_q, out_mask_d;
  logic signed [EW-1:0]       out_e_q [3];
  logic signed [EW-1:0]       out_e_d [3];
  logic signed [EW-1:0]       out_area_q, out_area_d;

  logic signed [EW-1:0]       area_s;
  logic signed [EW-1:0]       init_e_s [3];
  logic signed [EW-1:0]       lane_e_s [LANES][3];
  logic [LANES-1:0]           mask_s;
  logic signed [XW-1:0]       x_ext_s, xmax_ext_s;
  logic                       row_end_s, last_row_s, can_eval_s;

  // Area and the three edges at the clipped top-left corner, used by INIT.
  always_comb begin
    area_s = edge_eval(vx_q[2], vy_q[2], vx_q[0], vy_q[0], dx_q[2], dy_q[2]);
    for (int i = 0; i < 3; i++) begin
      init_e_s[i] = edge_eval(xmin_q, ymin_q, vx_q[(i+1)%3], vy_q[(i+1)%3], dx_q[i], dy_q[i]);
    end
  end

  // Per-lane edge values and coverage for the current scan position.
  always_comb begin
    x_ext_s    = XW'(x_q);
    xmax_ext_s = XW'(xmax_q);
    mask_s     = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < 3; i++) begin
        lane_e_s[k][i] = e_q[i] + $signed(EW'(k)) * dx_q[i];
      end
      mask_s[k] = !lane_e_s[k][0][EW-1] && !lane_e_s[k][1][EW-1] && !lane_e_s[k][2][EW-1] &&
                  ((x_ext_s + XW'(k)) <= xmax_ext_s);
    end
    row_end_s  = (x_ext_s + XW'(LANES)) > xmax_ext_s;
    last_row_s = (y_q == ymax_q);
    can_eval_s = !out_valid_q || i_ready;
  end

  // Next-state and datapath update for the rasteriser FSM.
  always_comb begin
    state_d     = state_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    tx0_d       = tx0_q;
    ty0_d       = ty0_q;
    tx1_d       = tx1_q;
    ty1_d       = ty1_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    e_d         = e_q;
    r_d         = r_q;
    area_d      = area_q;
    last_d      = last_q;
    out_valid_d = out_valid_q && !i_ready;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_mask_d  = out_mask_q;
    out_e_d     = out_e_q;
    out_area_d  = out_area_q;

    case (state_q)
      S_IDLE: begin
        if (i_draw) begin
          vx_d    = '{i_v1_x, i_v2_x, i_v3_x};
          vy_d    = '{i_v1_y, i_v2_y, i_v3_y};
          tx0_d   = i_tile_x0;
          ty0_d   = i_tile_y0;
          tx1_d   = i_tile_x1;
          ty1_d   = i_tile_y1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        xmin_d = smin(smin(vx_q[0], vx_q[1]), vx_q[2]);
        xmax_d = smax(smax(vx_q[0], vx_q[1]), vx_q[2]);
        ymin_d = smin(smin(vy_q[0], vy_q[1]), vy_q[2]);
        ymax_d = smax(smax(vy_q[0], vy_q[1]), vy_q[2]);
        // Edge i runs from vertex (i+1)%3 to vertex (i+2)%3.
        for (int i = 0; i < 3; i++) begin
          dx_d[i] = EW'(vy_q[(i+2)%3]) - EW'(vy_q[(i+1)%3]);
          dy_d[i] = EW'(vx_q[(i+1)%3]) - EW'(vx_q[(i+2)%3]);
        end
        state_d = S_CLIP;
      end
      S_CLIP: begin
        xmin_d = smax(xmin_q, tx0_q);
        xmax_d = smin(xmax_q, tx1_q);
        ymin_d = smax(ymin_q, ty0_q);
        ymax_d = smin(ymax_q, ty1_q);
        if ((xmin_d > xmax_d) || (ymin_d > ymax_d)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        x_d    = xmin_q;
        y_d    = ymin_q;
        last_d = 1'b0;
        if (area_s == '0) begin
          state_d = S_DONE;
        end else if (area_s[EW-1]) begin
`ifdef TRI_RASTER_BACKFACE_CULL_EN
          state_d = S_DONE;
`else
          // Flip winding so the inside test stays ">= 0" and the area positive.
          area_d = -area_s;
          for (int i = 0; i < 3; i++) begin
            e_d[i]  = -init_e_s[i];
            r_d[i]  = -init_e_s[i];
            dx_d[i] = -dx_q[i];
            dy_d[i] = -dy_q[i];
          end
          state_d = S_SCAN;
`endif
        end else begin
          area_d  = area_s;
          e_d     = init_e_s;
          r_d     = init_e_s;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (last_q) begin
          if (can_eval_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end else if (can_eval_s) begin
          if (mask_s != '0) begin
            out_valid_d = 1'b1;
            out_x_d     = x_q;
            out_y_d     = y_q;
            out_mask_d  = mask_s;
            out_e_d     = e_q;
            out_area_d  = area_q;
          end else begin
            out_mask_d  = out_mask_q;
          end
          if (row_end_s) begin
            if (last_row_s) begin
              if (mask_s != '0) begin
                last_d = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              x_d = xmin_q;
              y_d = y_q + COORD_W'(1'b1);
              for (int i = 0; i < 3; i++) begin
                e_d[i] = r_q[i] + dy_q[i];
                r_d[i] = r_q[i] + dy_q[i];
              end
            end
          end else begin
            x_d = x_q + COORD_W'(LANES);
            for (int i = 0; i < 3; i++) begin
              e_d[i] = e_q[i] + $signed(EW'(LANES)) * dx_q[i];
            end
          end
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 3; i++) begin
        vx_q[i]    <= '0;
        vy_q[i]    <= '0;
        dx_q[i]    <= '0;
        dy_q[i]    <= '0;
        e_q[i]     <= '0;
        r_q[i]     <= '0;
        out_e_q[i] <= '0;
      end
      tx0_q       <= '0;
      ty0_q       <= '0;
      tx1_q       <= '0;
      ty1_q       <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      area_q      <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_mask_q  <= '0;
      out_area_q  <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < 3; i++) begin
        vx_q[i]    <= vx_d[i];
        vy_q[i]    <= vy_d[i];
        dx_q[i]    <= dx_d[i];
        dy_q[i]    <= dy_d[i];
        e_q[i]     <= e_d[i];
        r_q[i]     <= r_d[i];
        out_e_q[i] <= out_e_d[i];
      end
      tx0_q       <= tx0_d;
      ty0_q       <= ty0_d;
      tx1_q       <= tx1_d;
      ty1_q       <= ty1_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      x_q         <= x_d;
      y_q         <= y_d;
      area_q      <= area_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_mask_q  <= out_mask_d;
      out_area_q  <= out_area_d;
    end
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = (state_q == S_DONE);
  assign o_valid = out_valid_q;
  assign o_x     = out_x_q;
  assign o_y     = out_y_q;
  assign o_mask  = out_mask_q;
  assign o_e1    = out_e_q[0];
  assign o_e2    = out_e_q[1];
  assign o_e3    = out_e_q[2];
  assign o_area  = out_area_q;

endmodule

// File: tb/tb_tri_tile_raster.sv
// Directed bench for tri_tile_raster: a LANES=1 and a LANES=4 instance share stimulus.
module tb_tri_tile_raster;

  localparam int CW = 16;
  localparam int EWT = 2*CW+2;

  typedef struct {
    int v1x, v1y, v2x, v2y, v3x, v3y;
    int tx0, ty0, tx1, ty1;
    int nb1, nb4, dc1, dc4, area;
  } case_t;

  typedef struct {
    int     x, y, mask;
    longint e1, e2, e3, area;
  } beat_t;

  logic clk, rst_n, draw, rdy1, rdy4;
  logic signed [CW-1:0] v1x, v1y, v2x, v2y, v3x, v3y, tx0, ty0, tx1, ty1;
  logic busy1, val1, done1, busy4, val4, done4;
  logic signed [CW-1:0] x1, y1, x4, y4;
  logic [0:0] m1;
  logic [3:0] m4;
  logic signed [EWT-1:0] e1_1, e2_1, e3_1, a_1, e1_4, e2_4, e3_4, a_4;

  tri_tile_raster #(.COORD_W(CW), .LANES(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_draw(draw),
    .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
    .i_tile_x0(tx0), .i_tile_y0(ty0), .i_tile_x1(tx1), .i_tile_y1(ty1),
    .o_busy(busy1), .o_valid(val1), .i_ready(rdy1), .o_x(x1), .o_y(y1), .o_mask(m1),
    .o_e1(e1_1), .o_e2(e2_1), .o_e3(e3_1), .o_area(a_1), .o_done(done1));

  tri_tile_raster #(.COORD_W(CW), .LANES(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_draw(draw),
    .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
    .i_tile_x0(tx0), .i_tile_y0(ty0), .i_tile_x1(tx1), .i_tile_y1(ty1),
    .o_busy(busy4), .o_valid(val4), .i_ready(rdy4), .o_x(x4), .o_y(y4), .o_mask(m4),
    .o_e1(e1_4), .o_e2(e2_4), .o_e3(e3_4), .o_area(a_4), .o_done(done4));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int t0 = 0;
  int fv1, fv4, dc1, dc4, d1_cnt, d4_cnt;
  beat_t b1[$];
  beat_t b4[$];
  bit stall4 = 1'b0;
  logic [171:0] prev4;
  case_t tc[7];
  int exp_x[6], exp_y[6], exp_m[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, collects accepted beats and done pulses.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stall4 = 1'b0;
      end else begin
        if (draw && !busy1) t0 = cyc;
        if (val1 && fv1 < 0) fv1 = cyc - t0;
        if (val4 && fv4 < 0) fv4 = cyc - t0;
        if (val1 && rdy1) b1.push_back('{int'(x1), int'(y1), int'(m1), longint'(e1_1),
                                         longint'(e2_1), longint'(e3_1), longint'(a_1)});
        if (val4 && rdy4) b4.push_back('{int'(x4), int'(y4), int'(m4), longint'(e1_4),
                                         longint'(e2_4), longint'(e3_4), longint'(a_4)});
        if (done1) begin d1_cnt++; dc1 = cyc - t0; end
        if (done4) begin d4_cnt++; dc4 = cyc - t0; end
        if (stall4) begin
          check("stall_valid", longint'(val4), 1);
          check("stall_hold", ({x4, y4, m4, e1_4, e2_4, e3_4, a_4} == prev4) ? 1 : 0, 1);
        end
        stall4 = val4 && !rdy4;
        prev4  = {x4, y4, m4, e1_4, e2_4, e3_4, a_4};
      end
    end
  end

  task automatic run_case(input case_t c, input int toggle);
    bit ok;
    int step;
    ok = 1'b0;
    step = 0;
    @(posedge clk); #1;
    b1.delete(); b4.delete();
    fv1 = -1; fv4 = -1; dc1 = -1; dc4 = -1; d1_cnt = 0; d4_cnt = 0;
    v1x = 16'(c.v1x); v1y = 16'(c.v1y); v2x = 16'(c.v2x); v2y = 16'(c.v2y);
    v3x = 16'(c.v3x); v3y = 16'(c.v3y);
    tx0 = 16'(c.tx0); ty0 = 16'(c.ty0); tx1 = 16'(c.tx1); ty1 = 16'(c.ty1);
    draw = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (d1_cnt > 0 && d4_cnt > 0) begin ok = 1'b1; break; end
      rdy4 = (toggle != 0) ? ((step % 4 == 0) || (step % 4 == 3)) : 1'b1;
      step++;
      @(posedge clk); #1;
    end
    rdy4 = 1'b1;
    check("done_within_bound", longint'(ok), 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_case(input case_t c, input string tag);
    int pix, bad_mask, bad_sum;
    pix = 0; bad_mask = 0; bad_sum = 0;
    check({tag, "_beats1"}, b1.size(), c.nb1);
    check({tag, "_beats4"}, b4.size(), c.nb4);
    check({tag, "_done1_cnt"}, d1_cnt, 1);
    check({tag, "_done4_cnt"}, d4_cnt, 1);
    check({tag, "_done1_cyc"}, dc1, c.dc1);
    check({tag, "_done4_cyc"}, dc4, c.dc4);
    foreach (b4[i]) pix += $countones(b4[i].mask);
    check({tag, "_pixels4"}, pix, c.nb1);
    foreach (b1[i]) begin
      if (b1[i].mask != 1) bad_mask++;
      if (b1[i].e1 + b1[i].e2 + b1[i].e3 != longint'(c.area)) bad_sum++;
      if (b1[i].area != longint'(c.area)) bad_sum++;
    end
    foreach (b4[i]) if (b4[i].area != longint'(c.area)) bad_sum++;
    check({tag, "_mask1_ones"}, bad_mask, 0);
    check({tag, "_edge_sum_area"}, bad_sum, 0);
    if (c.nb1 > 0) begin
      check({tag, "_first_valid1"}, fv1, 5);
      check({tag, "_first_valid4"}, fv4, 5);
    end else begin
      check({tag, "_no_valid1"}, fv1, -1);
    end
  endtask

  task automatic check_seq4(input string tag);
    check({tag, "_seq_len"}, b4.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < b4.size()) begin
        check($sformatf("%s_seq%0d_x", tag, i), b4[i].x, exp_x[i]);
        check($sformatf("%s_seq%0d_y", tag, i), b4[i].y, exp_y[i]);
        check($sformatf("%s_seq%0d_mask", tag, i), b4[i].mask, exp_m[i]);
      end
    end
  endtask

  initial begin
    bit ok;
    //        v1     v2      v3      tile              nb1 nb4 dc1 dc4 area
    tc[0] = '{0, 0,  0, 4,   4, 0,   0, 0, 319, 239,   15, 6,  29, 14, 16};
    tc[1] = '{0, 0,  0, 4,   4, 0,   2, 2, 319, 239,   1,  1,  13, 7,  16};
    tc[2] = '{0, 0,  0, 4,   4, 0,   10, 10, 20, 20,   0,  0,  3,  3,  0};
    tc[3] = '{0, 0,  2, 2,   4, 4,   0, 0, 319, 239,   0,  0,  4,  4,  0};
`ifdef TRI_RASTER_BACKFACE_CULL_EN
    tc[4] = '{0, 0,  4, 0,   0, 4,   0, 0, 319, 239,   0,  0,  4,  4,  0};
`else
    tc[4] = '{0, 0,  4, 0,   0, 4,   0, 0, 319, 239,   15, 6,  29, 14, 16};
`endif
    tc[5] = '{10, 10, 10, 13, 13, 10, 0, 0, 319, 239,  10, 4,  20, 9,  9};
    tc[6] = '{0, 0,  0, 4,   4, 0,   0, 0, 2, 319,     12, 5,  19, 10, 16};
    exp_x = '{0, 4, 0, 0, 0, 0};
    exp_y = '{0, 0, 1, 2, 3, 4};
    exp_m = '{15, 1, 15, 7, 3, 1};

    rst_n = 1'b1; draw = 1'b0; rdy1 = 1'b1; rdy4 = 1'b1;
    v1x = '0; v1y = '0; v2x = '0; v2y = '0; v3x = '0; v3y = '0;
    tx0 = '0; ty0 = '0; tx1 = '0; ty1 = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs1", longint'(|{busy1, val1, done1, x1, y1, m1, e1_1, e2_1, e3_1, a_1}), 0);
    check("reset_outputs4", longint'(|{busy4, val4, done4, x4, y4, m4, e1_4, e2_4, e3_4, a_4}), 0);
    rst_n = 1'b1;

    for (int ci = 0; ci < 7; ci++) begin
      run_case(tc[ci], 0);
      check_case(tc[ci], $sformatf("case%0d", ci));
      if (ci == 0) begin
        check_seq4("main4");
        check("main_e3_at_1_0_x", (b1.size() > 1) ? b1[1].x : -1, 1);
        check("main_e3_at_1_0", (b1.size() > 1) ? b1[1].e3 : -1, 4);
      end
    end

    // Downstream stalls with ready pattern 1,0,0,1,...
    run_case(tc[0], 1);
    check_seq4("stall4");
    check("stall4_done_cnt", d4_cnt, 1);

    // Reset in the middle of a scan, then a clean restart.
    @(posedge clk); #1;
    b1.delete(); b4.delete(); d1_cnt = 0; d4_cnt = 0;
    v1x = 16'(0); v1y = 16'(0); v2x = 16'(0); v2y = 16'(4); v3x = 16'(4); v3y = 16'(0);
    tx0 = 16'(0); ty0 = 16'(0); tx1 = 16'(319); ty1 = 16'(239);
    draw = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (b1.size() >= 3) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rst_reach_3_beats", longint'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midscan_reset1", longint'(|{busy1, val1, done1, x1, y1, m1, e1_1, e2_1, e3_1, a_1}), 0);
    check("midscan_reset4", longint'(|{busy4, val4, done4, x4, y4, m4, e1_4, e2_4, e3_4, a_4}), 0);
    d1_cnt = 0; d4_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_done1", d1_cnt, 0);
    check("no_stale_done4", d4_cnt, 0);
    run_case(tc[0], 0);
    check_case(tc[0], "after_reset");
    check_seq4("after_reset4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tri_tile_raster.md
# tri_tile_raster

Parametrised triangle scan-conversion front end for the raster pipeline. It takes three integer-coordinate vertices and a run-time tile rectangle, and clips the triangle's bounding box to the tile. It then walks the box `LANES` pixels per beat using incremental edge functions. Per beat it emits a coverage mask, the lane-0 position and the lane-0 edge values over a valid/ready stream, skipping empty beats. It replaces the fixed-tile, single-pixel, no-backpressure front end, and its output feeds the barycentric/attribute pipeline stages.

## Interface
- `COORD_W`, 16: signed vertex/tile/pixel coordinate width.
- `LANES`, 4: pixels per beat along x; 1, 2, 4 or 8.
- `EW`, 2*COORD_W+2: signed edge/area width (derived, do not override).

- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  reset, asynchronous and active-low.
- `i_draw`  in  1  start request; accepted only while `o_busy`=0.
- `i_v1_x`, `i_v1_y`, `i_v2_x`, `i_v2_y`, `i_v3_x`, `i_v3_y`  in  COORD_W each  signed vertex coordinates, sampled with an accepted `i_draw`.
- `i_tile_x0`, `i_tile_y0`, `i_tile_x1`, `i_tile_y1`  in  COORD_W each  inclusive tile rectangle, sampled with an accepted `i_draw`.
- `o_busy`  out  1  high from the cycle after acceptance through the `o_done` cycle.
- `o_valid`  out  1  beat available.
- `i_ready`  in  1  downstream accepts the beat.
- `o_x`, `o_y`  out  COORD_W  lane-0 pixel of the beat.
- `o_mask`  out  LANES  bit k set means pixel (o_x+k, o_y) is covered.
- `o_e1`, `o_e2`, `o_e3`  out  EW  sign-normalised edge values at lane 0.
- `o_area`  out  EW  sign-normalised doubled area (always >0 when a beat is emitted).
- `o_done`  out  1  one-cycle pulse at the end of the triangle.

## Operation
- Edge functions: E(a,b)(x,y) = (x-xa)*(yb-ya) - (y-ya)*(xb-xa).
  - e1 = E(v2,v3), e2 = E(v3,v1), e3 = E(v1,v2).
  - area = E(v1,v2) evaluated at v3.
- Steps: per pixel in x, +(yb-ya); per row in y, -(xb-xa). All arithmetic is signed EW bits; no saturation is needed.
- States:
  - IDLE: `i_draw` latches the inputs and moves to SETUP.
  - SETUP: bbox = per-axis min/max of the vertices.
  - CLIP: intersect the bbox with the tile. If x_min>x_max or y_min>y_max, go to DONE.
  - INIT: compute area and the three edges at (x_min, y_min) into the row-start and current registers.
    - area==0: go to DONE.
    - area<0: see Configuration.
    - otherwise go to SCAN.
  - SCAN: each advance evaluates lanes k=0..LANES-1 as e_i + k*dx_i.
    - Lane k is covered when all three values are >=0 and x+k <= x_max.
    - A nonzero mask loads the output register.
    - A zero mask advances without emitting.
    - Advance x by LANES. When x+LANES > x_max, go to (x_min, y+1) from the row-start registers.
    - After the last row, go to DONE once the output register is empty.
  - DONE: pulse `o_done`, then return to IDLE.
- Handshake:
  - All outputs stay stable while `o_valid`=1 and `i_ready`=0.
  - SCAN evaluates only when the output register is empty or is being accepted in the same cycle.
- `i_draw` while busy is ignored.
- `i_reset_n` low at any time (including mid-scan) clears all state immediately. No `o_done` is produced for the aborted triangle.

## Timing
- Reset values: `o_valid`=0, `o_done`=0, `o_busy`=0; `o_x`, `o_y`, `o_mask`, `o_e1`, `o_e2`, `o_e3`, `o_area` = 0.
- Start sequence: `i_draw` accepted at cycle 0; SETUP at 1, CLIP at 2, INIT at 3.
- First beat: the first SCAN evaluation is at cycle 4, so the earliest `o_valid` is at cycle 5.
- Throughput: one beat per cycle with `i_ready` held high, including empty-beat skips.
- Early termination (degenerate, culled or empty clip): `o_done` is high at cycle 4 (empty clip: cycle 3).
- Normal end: `o_done` pulses the cycle after the final beat's handshake. If trailing beats are empty, it pulses the cycle after the last scan position.
- Back-to-back: the next `i_draw` is accepted in the cycle after `o_done`.

## Configuration
- `TRI_RASTER_BACKFACE_CULL_EN` defined: area<0 means the triangle is culled. It goes INIT→DONE with no beats.
- Not defined: area<0 triangles are rasterised. Area, edges and steps are negated in INIT, so the inside test stays >=0 and `o_area` >0.

## Test plan
- v1=(0,0), v2=(0,4), v3=(4,0), tile (0,0)-(319,239), LANES=1, `i_ready`=1 -> 15 beats, each with mask 1, covering x+y<=4; `o_area`=16; `o_e3` at (1,0)=4; single `o_done`.
- Same triangle, LANES=4 -> 6 beats, in order:
  - (0,0) mask 1111; (4,0) mask 0001;
  - (0,1) 1111; (0,2) 0111; (0,3) 0011; (0,4) 0001.
- Same triangle, tile (2,2)-(319,239) -> exactly one beat at (2,2), mask 1 (LANES=1), then `o_done`.
- Swap v2 and v3 (area -16):
  - with `TRI_RASTER_BACKFACE_CULL_EN` -> no `o_valid`, `o_done` at cycle 4;
  - without it -> the same 15 beats, `o_area`=16.
- LANES=4 with `i_ready` toggling 1,0,0,1,… -> beat contents are unchanged across stall cycles; the sequence matches the LANES=4 case; no beats are lost or duplicated.
- Assert `i_reset_n`=0 after the 3rd beat -> all outputs return to 0 asynchronously. A new `i_draw` after release rasterises correctly, and no stale `o_done` appears.
